mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// - Shares the single-port CPU memory between instruction fetch (I) and data load/store (D).
// - Sits between the CPU core and the memory block.
// - The memory performs its read/write on the falling clk edge and registers dataOut there.
// - This block registers one access per grant, drives the memory for exactly one cycle,
//   and returns the result to the winning requester with a one-cycle valid pulse.
// PARAMETERS
// - ADDR_WIDTH  32  width of all address buses
// - DATA_WIDTH  32  width of all data buses
// - FAIR        1   1: alternate I/D when both request; 0: D always wins
// PORTS
// - clk         in   1           single clock, rising-edge logic; memory acts on falling edge
// - reset_n     in   1           asynchronous, active-low reset
// - i_req       in   1           fetch request; held with i_addr until i_gnt
// - i_addr      in   ADDR_WIDTH  fetch address
// - i_gnt       out  1           fetch request accepted this cycle (combinational)
// - i_rdata     out  DATA_WIDTH  fetched word; holds until next i_rvalid
// - i_rvalid    out  1           one-cycle pulse, i_rdata valid
// - d_req       in   1           data request; held with d_we/d_addr/d_wdata until d_gnt
// - d_we        in   1           1 = store, 0 = load
// - d_addr      in   ADDR_WIDTH  data address
// - d_wdata     in   DATA_WIDTH  store data
// - d_gnt       out  1           data request accepted this cycle (combinational)
// - d_rdata     out  DATA_WIDTH  load result; for a store, the prior memory contents
// - d_rvalid    out  1           one-cycle pulse: load data valid or store complete
// - mem_address out  ADDR_WIDTH  to memory address (registered)
// - mem_we      out  1           to memory writeEnable (registered)
// - mem_din     out  DATA_WIDTH  to memory dataIn (registered)
// - mem_dout    in   DATA_WIDTH  from memory dataOut
// BEHAVIOUR
// - Reset (async): state=IDLE; mem_we=0; mem_address=0; mem_din=0; i/d_rvalid=0;
//   i/d_rdata=0; last_winner=I (so D wins the first tie).
// - FSM states: IDLE, BUSY_I, BUSY_D.
// - IDLE, no req: stay in IDLE; gnts are 0; mem_we=0.
// - IDLE, req present: gnt=1 for the winner in the same cycle.
//   - At the rising edge, register mem_address/mem_we/mem_din from the winner and go to BUSY_x.
//   - mem_we=d_we only for a D grant; 0 for an I grant.
// - BUSY_x: no gnt is issued.
//   - The memory acts on the mid-cycle falling edge.
//   - At the next rising edge: x_rdata<=mem_dout, x_rvalid<=1, mem_we<=0, state=IDLE.
// - Latency: gnt in cycle N, rvalid/rdata in cycle N+2.
//   - Max throughput is one access per 2 cycles.
//   - A new gnt may coincide with the previous rvalid.
// - Arbitration when both request in IDLE:
//   - FAIR=1: grant the requester opposite to last_winner.
//   - FAIR=0: D always wins.
//   - last_winner updates on every grant.
// - Single requester: it is granted regardless of FAIR.
// - mem_we is high only during a BUSY_D store cycle.
//   - No spurious write on any other cycle, including the cycle after reset release.
// - Requester dropping req before gnt: the request is withdrawn; no access is made.
// - Requester changing addr while req high and not yet granted: the value sampled at the
//   granting edge is used.
// - rvalid is a single-cycle pulse; rdata holds its value afterwards.
// - The other port's rdata/rvalid are unaffected.
// - Reset mid-access: state returns to IDLE immediately; mem_we drops asynchronously.
//   - A store whose falling edge has not yet occurred is suppressed.
//   - No rvalid is issued for the abandoned access.
// - Address width: mem_address passes ADDR_WIDTH bits unmodified; no range check.
// TESTING
// - Reset: hold reset_n=0 3 cycles with random inputs
//   -> mem_we=0, gnts=0, rvalids=0, mem_address=0.
// - Lone fetch: mem[4]=0xDEADBEEF, i_req addr=4 in cycle 0
//   -> i_gnt=1 in cycle 0, mem_address=4 in cycle 1, i_rvalid=1 with i_rdata=0xDEADBEEF in cycle 2.
// - Store then load: d_we=1 addr=7 wdata=0x12345678
//   -> d_rvalid in cycle 2 with mem_we high in cycle 1 only.
//   -> A following load of addr 7 returns 0x12345678.
// - Contention FAIR=1: i_req and d_req held high 8 cycles
//   -> grants go D,I,D,I, one every 2 cycles; FAIR=0 -> all D, I starved.
// - Withdrawn request: i_req pulsed 1 cycle while BUSY_D
//   -> no i_gnt and no i_rvalid; memory is unaffected.
// - Reset mid-store: reset_n=0 asserted after the rising edge entering BUSY_D, before the falling edge
//   -> the target word is unchanged and no d_rvalid is issued.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction fetch and data load/store onto one single-port memory
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FAIR       = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_d;     // 1 when D won the most recent grant
    logic   take_i;
    logic   take_d;

    always_comb begin
        state_nxt = state;
        take_i    = 1'b0;
        take_d    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, D wins when unfair or when I won last time
                if (d_req && (!i_req || FAIR == 0 || !last_d)) begin
                    take_d    = 1'b1;
                    state_nxt = BUSY_D;
                end else if (i_req) begin
                    take_i    = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I:  state_nxt = IDLE;
            BUSY_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are suppressed while reset is held so no requester sees acceptance
    assign i_gnt = take_i & reset_n;
    assign d_gnt = take_d & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_d      <= 1'b0;
            mem_address <= '0;
            mem_we      <= 1'b0;
            mem_din     <= '0;
            i_rdata     <= '0;
            i_rvalid    <= 1'b0;
            d_rdata     <= '0;
            d_rvalid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_d) begin
                        mem_address <= d_addr;
                        mem_we      <= d_we;
                        mem_din     <= d_wdata;
                        last_d      <= 1'b1;
                    end else if (take_i) begin
                        mem_address <= i_addr;
                        mem_we      <= 1'b0;
                        last_d      <= 1'b0;
                    end
                end
                BUSY_I: begin
                    i_rdata  <= mem_dout;
                    i_rvalid <= 1'b1;
                    mem_we   <= 1'b0;
                end
                BUSY_D: begin
                    d_rdata  <= mem_dout;
                    d_rvalid <= 1'b1;
                    mem_we   <= 1'b0;
                end
                default: mem_we <= 1'b0;
            endcase
        end
    end

endmodule
